// File: rtl/debug_pkg.sv
// Shared constants and types for the pipeline debug controller:
// host command bytes, controller states and dump geometry.
package debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_END  = 8'h45;

    // PC and cycle count precede the register file in every report
    localparam int HDR_WORDS  = 2;
    localparam int REG_WORDS  = 32;
    localparam int DUMP_IDX_W = 7;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        STEP,
        DUMP_SEL,
        DUMP_SEND,
        DUMP_WAIT
    } state_t;

    function automatic int dump_words(input int dmem_dump);
        return HDR_WORDS + REG_WORDS + dmem_dump;
    endfunction

endpackage

// File: rtl/debug_unit_if.sv
// Byte-stream handshake between the debug controller and the UART rx/tx blocks.
interface debug_unit_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_done;

    modport master (input rx_data, rx_done, tx_done, output tx_data, tx_start);
    modport slave  (output rx_data, rx_done, tx_done, input tx_data, tx_start);
endinterface

// File: rtl/dbg_word_tx.sv
// Word-to-bytes serializer for the dump path: holds one word, presents it
// MSB byte first and steps to the next byte on each acknowledged transfer.
module dbg_word_tx #(
    parameter int N_BITS = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [N_BITS-1:0] i_word,
    input  logic              i_send,
    input  logic              i_ack,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    output logic              o_last
);
    localparam int N_BYTES = N_BITS / 8;
    localparam int BW      = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [N_BITS-1:0] word_q;
    logic [BW-1:0]     byte_idx;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (i_load) begin
            word_q   <= i_word;
            byte_idx <= '0;
        end else if (i_ack) begin
            byte_idx <= byte_idx + 1'b1;
        end
    end

    assign o_tx_data  = 8'(word_q >> ((N_BYTES - 1 - int'(byte_idx)) * 8));
    assign o_tx_start = i_send;
    assign o_last     = (byte_idx == BW'(N_BYTES - 1));
endmodule

// File: rtl/debug_unit.sv
// Debug controller between the UART and the pipeline: program load,
// continuous/step execution control and the PC/cycles/regs/dmem report.
//
// state     | meaning
// IDLE      | waiting for L / C / S
// LOAD      | assembling 4-byte words into instruction memory
// RUN       | core free-running until halt
// STEP      | core gated, one step per 'N', 'E' leaves
// DUMP_SEL  | select next report word and latch it into the serializer
// DUMP_SEND | start transmission of the current byte
// DUMP_WAIT | wait for the transmitter to finish the byte
module debug_unit
    import debug_pkg::*;
#(
    parameter int                N_BITS    = 32,
    parameter int                IMEM_AW   = 8,
    parameter int                DMEM_AW   = 5,
    parameter int                DMEM_DUMP = 16,
    parameter logic [N_BITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    debug_unit_if.master       uart,
    input  logic               i_halt,
    input  logic [N_BITS-1:0]  i_pc,
    input  logic [N_BITS-1:0]  i_ciclos,
    output logic [4:0]         o_reg_sel,
    input  logic [N_BITS-1:0]  i_reg_data,
    output logic [DMEM_AW-1:0] o_dmem_addr,
    input  logic [N_BITS-1:0]  i_dmem_data,
    output logic               o_imem_we,
    output logic [IMEM_AW-1:0] o_imem_addr,
    output logic [N_BITS-1:0]  o_imem_data,
    output logic               o_valid,
    output logic               o_exec_mode,
    output logic               o_step,
    output logic               o_busy
);
    localparam logic [DUMP_IDX_W-1:0] REG_FIRST  = DUMP_IDX_W'(HDR_WORDS);
    localparam logic [DUMP_IDX_W-1:0] DMEM_FIRST = DUMP_IDX_W'(HDR_WORDS + REG_WORDS);
    localparam logic [DUMP_IDX_W-1:0] LAST_WORD  = DUMP_IDX_W'(dump_words(DMEM_DUMP) - 1);

    state_t                  state, state_n;
    logic [N_BITS-9:0]       load_buf, load_buf_n;
    logic [1:0]              byte_cnt, byte_cnt_n;
    logic [IMEM_AW-1:0]      word_cnt, word_cnt_n, imem_addr_n;
    logic [N_BITS-1:0]       imem_data_n, load_word, dump_word;
    logic [N_BITS-1:0]       pc_lat, pc_n, cyc_lat, cyc_n;
    logic [DUMP_IDX_W-1:0]   word_idx, word_idx_n;
    logic                    imem_we_n, valid_n, exec_n, step_n;
    logic                    from_step, from_step_n, enter_dump;
    logic                    ser_last, ser_start;
    logic [7:0]              ser_data;

    assign load_word = {load_buf, uart.rx_data};
    assign o_busy    = (state != IDLE);

    assign o_reg_sel   = (word_idx >= REG_FIRST && word_idx < DMEM_FIRST) ?
                         5'(word_idx - REG_FIRST) : 5'd0;
    assign o_dmem_addr = (word_idx >= DMEM_FIRST) ? DMEM_AW'(word_idx - DMEM_FIRST) : '0;

    always_comb begin
        if (word_idx == '0)                          dump_word = pc_lat;
        else if (word_idx == DUMP_IDX_W'(1))         dump_word = cyc_lat;
        else if (word_idx < DMEM_FIRST)              dump_word = i_reg_data;
        else                                         dump_word = i_dmem_data;
    end

    dbg_word_tx #(.N_BITS(N_BITS)) u_word_tx (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (state == DUMP_SEL),
        .i_word    (dump_word),
        .i_send    (state == DUMP_SEND),
        .i_ack     (state == DUMP_WAIT && uart.tx_done),
        .o_tx_data (ser_data),
        .o_tx_start(ser_start),
        .o_last    (ser_last)
    );

    assign uart.tx_data  = ser_data;
    assign uart.tx_start = ser_start;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            load_buf    <= '0;
            byte_cnt    <= '0;
            word_cnt    <= '0;
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            o_valid     <= 1'b0;
            o_exec_mode <= 1'b0;
            o_step      <= 1'b0;
            word_idx    <= '0;
            pc_lat      <= '0;
            cyc_lat     <= '0;
            from_step   <= 1'b0;
        end else begin
            state       <= state_n;
            load_buf    <= load_buf_n;
            byte_cnt    <= byte_cnt_n;
            word_cnt    <= word_cnt_n;
            o_imem_we   <= imem_we_n;
            o_imem_addr <= imem_addr_n;
            o_imem_data <= imem_data_n;
            o_valid     <= valid_n;
            o_exec_mode <= exec_n;
            o_step      <= step_n;
            word_idx    <= word_idx_n;
            pc_lat      <= pc_n;
            cyc_lat     <= cyc_n;
            from_step   <= from_step_n;
        end
    end

    always_comb begin
        state_n     = state;
        load_buf_n  = load_buf;
        byte_cnt_n  = byte_cnt;
        word_cnt_n  = word_cnt;
        imem_we_n   = 1'b0;
        imem_addr_n = o_imem_addr;
        imem_data_n = o_imem_data;
        valid_n     = o_valid;
        exec_n      = o_exec_mode;
        step_n      = 1'b0;
        word_idx_n  = word_idx;
        pc_n        = pc_lat;
        cyc_n       = cyc_lat;
        from_step_n = from_step;
        enter_dump  = 1'b0;

        case (state)
            IDLE: begin
                if (uart.rx_done) begin
                    if (uart.rx_data == CMD_LOAD) begin
                        state_n    = LOAD;
                        word_cnt_n = '0;
                        byte_cnt_n = '0;
                    end else if (uart.rx_data == CMD_RUN) begin
                        state_n = RUN;
                        valid_n = 1'b1;
                        exec_n  = 1'b0;
                    end else if (uart.rx_data == CMD_STEP) begin
                        state_n = STEP;
                        valid_n = 1'b1;
                        exec_n  = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (uart.rx_done) begin
                    if (byte_cnt == 2'd3) begin
                        imem_we_n   = 1'b1;
                        imem_addr_n = word_cnt;
                        imem_data_n = load_word;
                        word_cnt_n  = word_cnt + 1'b1;
                        byte_cnt_n  = '0;
                        // top address ends the load rather than wrapping onto word 0
                        if (load_word == HALT_WORD || word_cnt == '1) state_n = IDLE;
                    end else begin
                        load_buf_n = load_word[N_BITS-9:0];
                        byte_cnt_n = byte_cnt + 1'b1;
                    end
                end
            end
            RUN: begin
                if (i_halt) begin
                    valid_n     = 1'b0;
                    from_step_n = 1'b0;
                    enter_dump  = 1'b1;
                end
            end
            STEP: begin
                // the dump starts the cycle after the step pulse, so it reports post-step state
                if (o_step) begin
                    from_step_n = 1'b1;
                    enter_dump  = 1'b1;
                end else if (uart.rx_done) begin
                    if (uart.rx_data == CMD_NEXT) begin
                        step_n = 1'b1;
                    end else if (uart.rx_data == CMD_END) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        exec_n  = 1'b0;
                    end
                end
            end
            DUMP_SEL:  state_n = DUMP_SEND;
            DUMP_SEND: state_n = DUMP_WAIT;
            DUMP_WAIT: begin
                if (uart.tx_done) begin
                    if (!ser_last) begin
                        state_n = DUMP_SEND;
                    end else if (word_idx != LAST_WORD) begin
                        word_idx_n = word_idx + 1'b1;
                        state_n    = DUMP_SEL;
                    end else begin
                        word_idx_n = '0;
                        if (from_step && !i_halt) begin
                            state_n = STEP;
                        end else begin
                            state_n = IDLE;
                            valid_n = 1'b0;
                            exec_n  = 1'b0;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (enter_dump) begin
            state_n    = DUMP_SEL;
            word_idx_n = '0;
            pc_n       = i_pc;
            cyc_n      = i_ciclos;
        end
    end
endmodule

// File: tb/tb_debug_unit.sv
// Directed-plus-random bench for debug_unit: a byte-level UART responder,
// register/memory models and an expected report built from those models.
`timescale 1ns/1ps
module tb_debug_unit;
    import debug_pkg::*;

    localparam int N_BITS     = 32;
    localparam int IMEM_AW    = 8;
    localparam int DMEM_AW    = 5;
    localparam int DMEM_DUMP  = 16;
    localparam int DUMP_BYTES = 4 * (34 + DMEM_DUMP);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    debug_unit_if uart_if();

    logic               halt;
    logic [31:0]        pc, ciclos;
    logic [4:0]         reg_sel;
    logic [31:0]        reg_data, dmem_data;
    logic [DMEM_AW-1:0] dmem_addr;
    logic               imem_we, valid, exec_mode, step, busy;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;

    logic [31:0] regs [32];
    logic [31:0] dmem [32];
    assign reg_data  = regs[reg_sel];
    assign dmem_data = dmem[dmem_addr];

    debug_unit #(
        .N_BITS(N_BITS), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW),
        .DMEM_DUMP(DMEM_DUMP), .HALT_WORD(32'hFFFF_FFFF)
    ) dut (
        .i_clk(clk), .i_reset(rst_n), .uart(uart_if.master),
        .i_halt(halt), .i_pc(pc), .i_ciclos(ciclos),
        .o_reg_sel(reg_sel), .i_reg_data(reg_data),
        .o_dmem_addr(dmem_addr), .i_dmem_data(dmem_data),
        .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_data(imem_data),
        .o_valid(valid), .o_exec_mode(exec_mode), .o_step(step), .o_busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // UART transmitter model: accepts one byte per tx_start, answers tx_done after tx_delay cycles
    int         tx_delay = 0;
    int         pending = 0;
    int         countdown = 0;
    int         multi_start = 0;
    logic [7:0] cap_q [$];

    initial begin
        uart_if.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            uart_if.tx_done = 1'b0;
            if (!rst_n) begin
                pending = 0;
            end else begin
                if (pending != 0) begin
                    if (countdown == 0) begin
                        uart_if.tx_done = 1'b1;
                        pending = 0;
                    end else begin
                        countdown--;
                    end
                end
                if (uart_if.tx_start) begin
                    if (pending != 0) multi_start++;
                    else begin
                        cap_q.push_back(uart_if.tx_data);
                        pending   = 1;
                        countdown = tx_delay;
                    end
                end
            end
        end
    end

    int                 step_cycles = 0;
    int                 overlap = 0;
    logic [IMEM_AW-1:0] wr_addr_q [$];
    logic [31:0]        wr_data_q [$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (imem_we) begin
                    wr_addr_q.push_back(imem_addr);
                    wr_data_q.push_back(imem_data);
                end
                if (step) step_cycles++;
                if (step && imem_we) overlap++;
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_if.rx_data = b;
        uart_if.rx_done = 1'b1;
        @(negedge clk);
        uart_if.rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(8'(w >> (8 * i)));
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int cyc = 0;
        while (cap_q.size() < n && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check(tag, 64'(cap_q.size() >= n), 64'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int cyc = 0;
        while (busy !== 1'b0 && cyc < budget) begin
            sample();
            cyc++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic halt_pulse();
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 32; i++) begin
            regs[i] = $urandom;
            dmem[i] = $urandom;
        end
    endtask

    // Report = PC, cycles, r0..r31, dmem[0..DMEM_DUMP-1], each word MSB byte first
    task automatic check_dump(input logic [31:0] epc, input logic [31:0] ecyc, input string tag);
        logic [31:0] words [$];
        int bad;
        bad = 0;
        words.push_back(epc);
        words.push_back(ecyc);
        for (int i = 0; i < 32; i++) words.push_back(regs[i]);
        for (int i = 0; i < DMEM_DUMP; i++) words.push_back(dmem[i]);
        check({tag, "_len"}, 64'(cap_q.size()), 64'(words.size() * 4));
        for (int w = 0; w < words.size(); w++) begin
            for (int b = 0; b < 4; b++) begin
                logic [7:0] e;
                e = 8'(words[w] >> (8 * (3 - b)));
                if (4 * w + b >= cap_q.size()) bad++;
                else if (cap_q[4 * w + b] !== e) bad++;
            end
        end
        check({tag, "_bytes"}, 64'(bad), 64'd0);
        cap_q.delete();
    endtask

    initial begin
        logic [31:0] exp_words [$];
        logic [31:0] w, epc, ecyc;
        int bad;

        uart_if.rx_data = 8'h00;
        uart_if.rx_done = 1'b0;
        halt   = 1'b0;
        pc     = '0;
        ciclos = '0;
        randomize_mem();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {busy, valid, exec_mode, step, imem_we, imem_addr, imem_data,
               uart_if.tx_start, uart_if.tx_data, reg_sel, dmem_addr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed load terminated by HALT_WORD
        send_byte(CMD_LOAD);
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        sample();
        check("load_nwrites", 64'(wr_addr_q.size()), 64'd2);
        check("load_w0", {wr_addr_q[0], wr_data_q[0]}, {8'd0, 32'h2001_0005});
        check("load_w1", {wr_addr_q[1], wr_data_q[1]}, {8'd1, 32'hFFFF_FFFF});
        check("load_idle", 64'(busy), 64'd0);

        // random load, word count restarts at 0
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_words.delete();
        send_byte(CMD_LOAD);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
            exp_words.push_back(w);
            send_word(w);
        end
        exp_words.push_back(32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF);
        sample();
        check("rload_nwrites", 64'(wr_addr_q.size()), 64'd4);
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== IMEM_AW'(i) || wr_data_q[i] !== exp_words[i]) bad++;
        check("rload_content", 64'(bad), 64'd0);

        // full memory without HALT_WORD: last write at the top address ends the load
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_words.delete();
        send_byte(CMD_LOAD);
        for (int i = 0; i < (1 << IMEM_AW); i++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            exp_words.push_back(w);
            send_word(w);
        end
        sample();
        check("full_load_idle", 64'(busy), 64'd0);
        check("full_load_nwrites", 64'(wr_addr_q.size()), 64'(1 << IMEM_AW));
        bad = 0;
        for (int i = 0; i < (1 << IMEM_AW); i++)
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== IMEM_AW'(i) || wr_data_q[i] !== exp_words[i]) bad++;
        check("full_load_content", 64'(bad), 64'd0);

        // continuous run until halt
        randomize_mem();
        regs[5] = 32'd7;
        dmem[0] = 32'd3;
        pc      = 32'h8;
        ciclos  = 32'd50;
        cap_q.delete();
        send_byte(CMD_RUN);
        sample();
        check("run_ctrl", {busy, valid, exec_mode}, 3'b110);
        repeat (50) @(posedge clk);
        @(negedge clk);
        halt = 1'b1;
        sample();
        check("run_valid_drop", 64'(valid), 64'd0);
        @(negedge clk);
        halt   = 1'b0;
        pc     = $urandom;
        ciclos = $urandom;
        wait_bytes(DUMP_BYTES, 5000, "run_dump_wait");
        wait_idle(50, "run_idle");
        check("run_pc_bytes", {cap_q[0], cap_q[1], cap_q[2], cap_q[3]}, 32'h0000_0008);
        check("run_cyc_bytes", {cap_q[4], cap_q[5], cap_q[6], cap_q[7]}, 32'h0000_0032);
        check("run_r5_bytes", {cap_q[28], cap_q[29], cap_q[30], cap_q[31]}, 32'h0000_0007);
        check("run_dmem0_bytes", {cap_q[136], cap_q[137], cap_q[138], cap_q[139]}, 32'h0000_0003);
        check_dump(32'h8, 32'd50, "run_dump");
        check("run_no_step", 64'(step_cycles), 64'd0);

        // step mode: three steps, a stray byte, an 'E' sent during a dump, then exit
        step_cycles = 0;
        send_byte(CMD_STEP);
        sample();
        check("step_ctrl", {busy, valid, exec_mode}, 3'b111);
        send_byte(8'h58);
        check("step_ignore_other", 64'(step_cycles), 64'd0);
        for (int k = 0; k < 3; k++) begin
            randomize_mem();
            pc     = $urandom;
            ciclos = $urandom;
            epc    = pc;
            ecyc   = ciclos;
            send_byte(CMD_NEXT);
            pc     = $urandom;
            ciclos = $urandom;
            if (k == 1) begin
                wait_bytes(12, 2000, "step_mid_wait");
                send_byte(CMD_END);
            end
            wait_bytes(DUMP_BYTES, 5000, "step_dump_wait");
            repeat (4) @(posedge clk);
            #1;
            check("step_pulses", 64'(step_cycles), 64'(k + 1));
            check("step_back", {busy, valid, exec_mode}, 3'b111);
            check_dump(epc, ecyc, "step_dump");
        end
        send_byte(CMD_END);
        sample();
        check("step_exit", {busy, valid}, 2'b00);

        // step session where the third step reaches halt
        step_cycles = 0;
        send_byte(CMD_STEP);
        for (int k = 0; k < 3; k++) begin
            pc     = $urandom;
            ciclos = $urandom;
            epc    = pc;
            ecyc   = ciclos;
            if (k == 2) halt = 1'b1;
            send_byte(CMD_NEXT);
            wait_bytes(DUMP_BYTES, 5000, "hstep_dump_wait");
            repeat (4) @(posedge clk);
            #1;
            check_dump(epc, ecyc, "hstep_dump");
        end
        wait_idle(50, "hstep_idle");
        check("hstep_valid", 64'(valid), 64'd0);
        send_byte(CMD_NEXT);
        sample();
        check("hstep_no_pulse", 64'(step_cycles), 64'd3);
        halt = 1'b0;

        // slow transmitter: 1000-cycle tx_done latency for the first bytes
        randomize_mem();
        pc          = $urandom;
        ciclos      = $urandom;
        epc         = pc;
        ecyc        = ciclos;
        multi_start = 0;
        tx_delay    = 1000;
        send_byte(CMD_RUN);
        halt_pulse();
        wait_bytes(8, 20000, "slow_wait8");
        tx_delay = 0;
        wait_bytes(DUMP_BYTES, 20000, "slow_dump_wait");
        wait_idle(50, "slow_idle");
        check("slow_single_start", 64'(multi_start), 64'd0);
        check_dump(epc, ecyc, "slow_dump");

        // asynchronous reset in the middle of a report
        send_byte(CMD_RUN);
        halt_pulse();
        wait_bytes(37, 2000, "rst_wait37");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs",
              {busy, valid, exec_mode, step, imem_we, imem_addr, imem_data,
               uart_if.tx_start, uart_if.tx_data, reg_sel, dmem_addr}, 64'd0);
        repeat (3) @(negedge clk);
        cap_q.delete();
        rst_n = 1'b1;
        randomize_mem();
        pc     = $urandom;
        ciclos = $urandom;
        epc    = pc;
        ecyc   = ciclos;
        send_byte(CMD_RUN);
        halt_pulse();
        wait_bytes(DUMP_BYTES, 5000, "post_rst_wait");
        wait_idle(50, "post_rst_idle");
        check_dump(epc, ecyc, "post_rst_dump");
        check("step_we_overlap", 64'(overlap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
